// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: writeback trace FIFO with saturating cycle/stall/branch counters
module pipe_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     wb_en,
    input  logic [2:0]               wb_dr,
    input  logic [15:0]              wb_val,
    input  logic                     branch,
    input  logic                     stall,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [2:0]               rd_dr,
    output logic [15:0]              rd_val,
    output logic [CNT_W-1:0]         rd_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         branch_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 3 + 16 + CNT_W;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, stall_q, stall_d, branch_q, branch_d;
    logic             rd_valid_q, rd_valid_d;
    logic [2:0]       rd_dr_q, rd_dr_d;
    logic [15:0]      rd_val_q, rd_val_d;
    logic [CNT_W-1:0] rd_seq_q, rd_seq_d;
    logic             pop, push, drop;
    logic [EW-1:0]    head;

    // Next-state: pop only when data is present, push when room exists or a pop frees a slot; clr overrides all
    always_comb begin
        pop        = rd_en && !empty_q;
        push       = wb_en && (!full_q || pop);
        drop       = wb_en && full_q && !pop;
        head       = mem_q[rptr_q];
        level_d    = clr ? '0 : level_q + LW'(push) - LW'(pop);
        wptr_d     = clr ? '0 : wptr_q + AW'(push);
        rptr_d     = clr ? '0 : rptr_q + AW'(pop);
        full_d     = level_d == LW'(DEPTH);
        empty_d    = level_d == '0;
        overflow_d = !clr && (overflow_q || drop);
        cycle_d    = clr ? '0 : (&cycle_q ? cycle_q : cycle_q + 1'b1);
        stall_d    = clr ? '0 : ((stall && !(&stall_q)) ? stall_q + 1'b1 : stall_q);
        branch_d   = clr ? '0 : ((branch && !(&branch_q)) ? branch_q + 1'b1 : branch_q);
        rd_valid_d = !clr && pop;
        rd_dr_d    = clr ? '0 : (pop ? head[EW-1 -: 3] : rd_dr_q);
        rd_val_d   = clr ? '0 : (pop ? head[CNT_W +: 16] : rd_val_q);
        rd_seq_d   = clr ? '0 : (pop ? head[CNT_W-1:0] : rd_seq_q);
    end

    // Control, counter and readout registers with asynchronous reset
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            stall_q    <= '0;
            branch_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_dr_q    <= '0;
            rd_val_q   <= '0;
            rd_seq_q   <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
            branch_q   <= branch_d;
            rd_valid_q <= rd_valid_d;
            rd_dr_q    <= rd_dr_d;
            rd_val_q   <= rd_val_d;
            rd_seq_q   <= rd_seq_d;
        end
    end

    // Entry storage; stamp is the cycle count before this edge's increment
    always_ff @(posedge CLOCK_50) begin
        if (push && !clr)
            mem_q[wptr_q] <= {wb_dr, wb_val, cycle_q};
    end

    assign rd_valid   = rd_valid_q;
    assign rd_dr      = rd_dr_q;
    assign rd_val     = rd_val_q;
    assign rd_seq     = rd_seq_q;
    assign level      = level_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = overflow_q;
    assign cycle_cnt  = cycle_q;
    assign stall_cnt  = stall_q;
    assign branch_cnt = branch_q;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer: directed checks of the trace FIFO and counters
module tb_pipe_trace_buffer;
    logic        clk = 1'b0;
    logic        reset_n, clr, wb_en, branch, stall, rd_en;
    logic [2:0]  wb_dr;
    logic [15:0] wb_val;
    logic        rd_valid, full, empty, overflow;
    logic [2:0]  rd_dr;
    logic [15:0] rd_val, rd_seq, cycle_cnt, stall_cnt, branch_cnt;
    logic [4:0]  level;
    logic        s_rd_valid, s_full, s_empty, s_overflow;
    logic [2:0]  s_rd_dr;
    logic [15:0] s_rd_val;
    logic [3:0]  s_rd_seq, s_cycle_cnt, s_stall_cnt, s_branch_cnt;
    logic [4:0]  s_level;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_trace_buffer #(.DEPTH(16), .CNT_W(16)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .clr(clr), .wb_en(wb_en), .wb_dr(wb_dr),
        .wb_val(wb_val), .branch(branch), .stall(stall), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_dr(rd_dr), .rd_val(rd_val), .rd_seq(rd_seq),
        .level(level), .full(full), .empty(empty), .overflow(overflow),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .branch_cnt(branch_cnt)
    );

    pipe_trace_buffer #(.DEPTH(16), .CNT_W(4)) dut_small (
        .CLOCK_50(clk), .reset_n(reset_n), .clr(clr), .wb_en(wb_en), .wb_dr(wb_dr),
        .wb_val(wb_val), .branch(branch), .stall(stall), .rd_en(rd_en),
        .rd_valid(s_rd_valid), .rd_dr(s_rd_dr), .rd_val(s_rd_val), .rd_seq(s_rd_seq),
        .level(s_level), .full(s_full), .empty(s_empty), .overflow(s_overflow),
        .cycle_cnt(s_cycle_cnt), .stall_cnt(s_stall_cnt), .branch_cnt(s_branch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; wb_en = 1'b0; wb_dr = '0; wb_val = '0;
        branch = 1'b0; stall = 1'b0; rd_en = 1'b0;
        tick();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        // in-order capture with cycle stamps 2,3,5
        tick(); tick();
        chk("t1_cycle", cycle_cnt, 2);
        wb_en = 1'b1; wb_dr = 3'd1; wb_val = 16'h0005; tick();
        wb_dr = 3'd2; wb_val = 16'hFFFF; tick();
        wb_en = 1'b0; tick();
        wb_en = 1'b1; wb_dr = 3'd7; wb_val = 16'h1234; tick();
        wb_en = 1'b0;
        chk("t1_level3", level, 3);
        chk("t1_nempty", empty, 0);
        rd_en = 1'b1;
        tick();
        chk("t1_v0", rd_valid, 1); chk("t1_dr0", rd_dr, 1); chk("t1_val0", rd_val, 16'h0005);
        chk("t1_seq0", rd_seq, 2); chk("t1_lvl2", level, 2);
        tick();
        chk("t1_dr1", rd_dr, 2); chk("t1_val1", rd_val, 16'hFFFF); chk("t1_seq1", rd_seq, 3);
        tick();
        chk("t1_dr2", rd_dr, 7); chk("t1_val2", rd_val, 16'h1234); chk("t1_seq2", rd_seq, 5);
        chk("t1_lvl0", level, 0); chk("t1_empty", empty, 1);
        tick();
        chk("t1_emptyrd", rd_valid, 0); chk("t1_hold", rd_val, 16'h1234);
        rd_en = 1'b0;
        // fill to full, drop the 17th, drain in order
        do_clr();
        chk("t2_clrcyc", cycle_cnt, 0);
        for (int i = 1; i <= 17; i++) begin
            wb_en = 1'b1; wb_dr = 3'(i); wb_val = 16'(i);
            tick();
            if (i == 15) chk("t2_nfull15", full, 0);
            if (i == 16) begin
                chk("t2_full16", full, 1);
                chk("t2_noovf16", overflow, 0);
            end
        end
        wb_en = 1'b0;
        chk("t2_ovf", overflow, 1);
        chk("t2_lvl16", level, 16);
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("t2_val", rd_val, i);
            chk("t2_seq", rd_seq, i - 1);
            chk("t2_dr", rd_dr, i % 8);
        end
        rd_en = 1'b0;
        tick();
        chk("t2_empty", empty, 1); chk("t2_ovfsticky", overflow, 1);
        // simultaneous push/pop while full
        do_clr();
        for (int i = 1; i <= 16; i++) begin
            wb_en = 1'b1; wb_dr = 3'd3; wb_val = 16'(16'h100 + i);
            tick();
        end
        chk("t3_full", full, 1);
        wb_val = 16'h0200; wb_dr = 3'd5; rd_en = 1'b1;
        tick();
        wb_en = 1'b0;
        chk("t3_lvl", level, 16); chk("t3_fullk", full, 1); chk("t3_noovf", overflow, 0);
        chk("t3_valid", rd_valid, 1); chk("t3_val", rd_val, 16'h0101);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("t3_drain", rd_val, 16'h100 + i);
        end
        tick();
        chk("t3_last", rd_val, 16'h0200); chk("t3_lastdr", rd_dr, 5); chk("t3_empty", empty, 1);
        // simultaneous push/pop while empty: no fall-through
        wb_en = 1'b1; wb_val = 16'hABCD; wb_dr = 3'd4;
        tick();
        wb_en = 1'b0;
        chk("t4_lvl", level, 1); chk("t4_novalid", rd_valid, 0);
        tick();
        rd_en = 1'b0;
        chk("t4_valid", rd_valid, 1); chk("t4_val", rd_val, 16'hABCD); chk("t4_lvl0", level, 0);
        tick();
        chk("t4_pulse", rd_valid, 0);
        // counters and saturation
        do_clr();
        stall = 1'b1; repeat (4) tick();
        stall = 1'b0; branch = 1'b1; repeat (2) tick();
        branch = 1'b0;
        chk("t5_stall", stall_cnt, 4); chk("t5_branch", branch_cnt, 2); chk("t5_cycle", cycle_cnt, 6);
        chk("t5_scycle", s_cycle_cnt, 6);
        repeat (12) tick();
        chk("t5_cyc18", cycle_cnt, 18); chk("t5_ssat", s_cycle_cnt, 15);
        stall = 1'b1; repeat (14) tick();
        stall = 1'b0;
        chk("t5_stall18", stall_cnt, 18); chk("t5_sstallsat", s_stall_cnt, 15);
        chk("t5_sbranch", s_branch_cnt, 2);
        // async reset in the middle of a pop
        wb_en = 1'b1; wb_val = 16'h0011; tick();
        wb_val = 16'h0022; tick();
        wb_en = 1'b0; rd_en = 1'b1;
        tick();
        chk("t6_prevalid", rd_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid", rd_valid, 0); chk("t6_lvl", level, 0); chk("t6_empty", empty, 1);
        chk("t6_val", rd_val, 0); chk("t6_cycle", cycle_cnt, 0); chk("t6_stall", stall_cnt, 0);
        rd_en = 1'b0;
        tick();
        reset_n = 1'b1;
        // clr beats a concurrent write and pop
        wb_en = 1'b1; wb_val = 16'h0033; tick();
        wb_val = 16'h0044; tick();
        chk("t6_lvl2", level, 2);
        clr = 1'b1; wb_val = 16'h0055; rd_en = 1'b1;
        tick();
        clr = 1'b0; wb_en = 1'b0;
        chk("t6c_lvl", level, 0); chk("t6c_empty", empty, 1); chk("t6c_valid", rd_valid, 0);
        chk("t6c_cycle", cycle_cnt, 0); chk("t6c_ovf", overflow, 0);
        tick();
        rd_en = 1'b0;
        chk("t6c_nostore", rd_valid, 0); chk("t6c_lvl0", level, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
